// File: rtl/nv_nvdla_glb_ic_param.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_glb_ic_param
// Brief    : Global interrupt controller. Captures per-source done pulses
//            into write-1-clear status, applies a mask and drives a
//            registered level interrupt to the host. Optional interrupt
//            coalescing (count threshold / timeout) is compiled in with
//            the macro NVDLA_GLB_IC_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_glb_ic_param #(
  parameter int NUM_SRC = 8,
  parameter int EVT_W   = 2
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic [NUM_SRC*EVT_W-1:0]   src_done_intr_pd,
  input  logic                       reg_wr_en,
  input  logic                       reg_rd_en,
  input  logic [1:0]                 reg_offset,
  input  logic [31:0]                reg_wr_data,
  output logic [31:0]                reg_rd_data,
  output logic                       reg_rd_valid,
  output logic                       core_intr
);

  localparam int W = NUM_SRC * EVT_W;

  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_SET  = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_CFG  = 2'd3;

  // Register write decode
  logic         wr_mask;
  logic         wr_set;
  logic         wr_stat;
  logic         wr_cfg;
  logic [W-1:0] wdat;

  assign wr_mask = reg_wr_en && (reg_offset == OFF_MASK);
  assign wr_set  = reg_wr_en && (reg_offset == OFF_SET);
  assign wr_stat = reg_wr_en && (reg_offset == OFF_STAT);
  assign wr_cfg  = reg_wr_en && (reg_offset == OFF_CFG);
  assign wdat    = reg_wr_data[W-1:0];

  // Upper write-data bits are don't-care for some registers/builds
  logic unused_wr_data;
  assign unused_wr_data = ^{reg_wr_data, wr_cfg};

  logic [W-1:0] status_q, status_d;
  logic [W-1:0] mask_q,   mask_d;
  logic         pending;

  // Next status/mask: set sources beat write-1-clear on the same bit
  always_comb begin
    status_d = (status_q & ~(wr_stat ? wdat : {W{1'b0}}))
             | src_done_intr_pd
             | (wr_set ? wdat : {W{1'b0}});
    mask_d   = wr_mask ? wdat : mask_q;
  end

  // Status and mask storage
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
    end
  end

  // Pending is derived from the already-updated (registered) status and mask
  assign pending = |(status_q & ~mask_q);

  logic [31:0] cfg_rd;
  logic        core_intr_d;
  logic        core_intr_q;

`ifdef NVDLA_GLB_IC_COALESCE_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   th_q;
  logic [15:0]  to_q;
  logic [7:0]   cnt_q, cnt_d;
  logic [15:0]  tmr_q, tmr_d;
  logic [W-1:0] rise;
  logic [5:0]   rise_num;
  logic [8:0]   cnt_sum;
  logic         clr_cnt;

  assign cfg_rd = {8'h00, to_q, th_q};

  // Count unmasked status bits that go 0->1 on this edge
  always_comb begin
    rise     = status_d & ~status_q & ~mask_d;
    rise_num = '0;
    for (int j = 0; j < W; j++) begin
      rise_num = rise_num + {5'd0, rise[j]};
    end
  end

  // Coalesce FSM next state, timer and saturating count
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (pending) begin
          state_d = (th_q <= 8'd1) ? ST_FIRE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!pending) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
          tmr_d   = '0;
        end else begin
          if ((cnt_q >= th_q) || ((to_q != 16'd0) && (tmr_q == to_q - 16'd1))) begin
            state_d = ST_FIRE;
          end
          if (tmr_q != 16'hFFFF) begin
            tmr_d = tmr_q + 16'd1;
          end
        end
      end
      ST_FIRE: begin
        if (!pending) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clr_cnt = 1'b1;
        tmr_d   = '0;
      end
    endcase
    cnt_sum     = {1'b0, (clr_cnt ? 8'd0 : cnt_q)} + {3'd0, rise_num};
    cnt_d       = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    core_intr_d = (state_d == ST_FIRE);
  end

  // Coalesce state, counters and CFG register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      th_q    <= 8'd1;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      if (wr_cfg) begin
        th_q <= reg_wr_data[7:0];
        to_q <= reg_wr_data[23:8];
      end
    end
  end
`else
  // Without coalescing the interrupt simply follows pending one edge later
  assign cfg_rd      = 32'h0000_0000;
  assign core_intr_d = pending;
`endif

  // Interrupt output register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      core_intr_q <= 1'b0;
    end else begin
      core_intr_q <= core_intr_d;
    end
  end

  assign core_intr = core_intr_q;

  // Read mux samples pre-write register contents
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (reg_offset)
      OFF_MASK: rd_mux[W-1:0] = mask_q;
      OFF_SET:  rd_mux        = '0;
      OFF_STAT: rd_mux[W-1:0] = status_q;
      OFF_CFG:  rd_mux        = cfg_rd;
      default:  rd_mux        = '0;
    endcase
  end

  logic        rd_pend_q;
  logic [31:0] rd_hold_q;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;

  // Two-stage read pipeline: capture at the request edge, present one edge later
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_pend_q  <= 1'b0;
      rd_hold_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= reg_rd_en;
      rd_hold_q  <= reg_rd_en ? rd_mux : 32'h0000_0000;
      rd_valid_q <= rd_pend_q;
      rd_data_q  <= rd_hold_q;
    end
  end

  assign reg_rd_valid = rd_valid_q;
  assign reg_rd_data  = rd_data_q;

endmodule
`default_nettype wire
